// File: rtl/mac_shift_pkg.sv
// mac_shift_pkg: shared types and constants for the MAC alignment shifter.
//   shift_mode_t : runtime shift mode, encoded as on the in_mode port.
//   f_lvls       : number of binary shift levels for a given data width.
//   LVLS         : level count for the default 32-bit datapath.
package mac_shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_t;

  function automatic int f_lvls(input int w);
    return $clog2(w);
  endfunction

  localparam int DEF_WIDTH = 32;
  localparam int LVLS      = f_lvls(DEF_WIDTH);

endpackage

// File: rtl/mac_shift_level.sv
// mac_shift_level: one binary level of the right barrel shifter.
//   i_data/o_data : word in / word out (shifted right by DIST when i_en)
//   i_en          : apply this level
//   i_mode        : ROR recirculates the low bits, other modes fill
//   i_fill        : fill bit for the vacated top positions
//   o_disc        : bits dropped off the bottom (zero for ROR or when idle)
module mac_shift_level
  import mac_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  shift_mode_t      i_mode,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data,
  output logic [DIST-1:0]  o_disc
);

  logic [DIST-1:0] w_top;

  always_comb begin
    w_top  = (i_mode == MODE_ROR) ? i_data[DIST-1:0] : {DIST{i_fill}};
    o_data = i_en ? {w_top, i_data[WIDTH-1:DIST]} : i_data;
    o_disc = (i_en && i_mode != MODE_ROR) ? i_data[DIST-1:0] : '0;
  end

endmodule

// File: rtl/mac_align_shifter.sv
// mac_align_shifter: two-stage pipelined barrel shifter for MAC operand alignment.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake (in_ready low while rst)
//   in_data/in_shift/in_mode : operand, shift amount, mode (LSR/ASR/LSL/ROR)
//   out_valid/out_ready  : output handshake
//   out_data/out_sticky/out_ovf : result, OR of discarded bits, over-range flag
// S1 runs the large-distance levels, S2 the rest; LSL is done as a right
// shift on a bit-reversed word.
module mac_align_shifter
  import mac_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic               out_ovf
);

  localparam int LV = f_lvls(WIDTH);
  localparam int H  = (LV + 1) / 2;  // levels done in S1

  function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] d);
    for (int i = 0; i < WIDTH; i++) f_rev[i] = d[WIDTH-1-i];
  endfunction

  // S1 / S2 state
  logic              r_s1_vld, r_s2_vld;
  logic [WIDTH-1:0]  r_s1_data;
  logic [LV-H-1:0]   r_s1_amt;
  shift_mode_t       r_s1_mode;
  logic              r_s1_fill, r_s1_ovf, r_s1_sticky;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_sticky, r_out_ovf;

  shift_mode_t       w_mode;
  logic              w_fill, w_ovf, w_s1_ld, w_s2_adv;
  logic [WIDTH-1:0]  w_s1_data, w_s2_data;
  logic              w_s1_sticky, w_s2_sticky;
  logic [LV:0][WIDTH-1:0] w_ch;
  logic [LV-1:0]     w_dor;

  assign w_mode = shift_mode_t'(in_mode);
  assign w_fill = (w_mode == MODE_ASR) & in_data[WIDTH-1];
  // any set bit above the level range means shift >= WIDTH
  assign w_ovf  = (w_mode != MODE_ROR) && (|in_shift[SHIFT_W-1:LV]);
  assign w_ch[0] = (w_mode == MODE_LSL) ? f_rev(in_data) : in_data;

  for (genvar j = 0; j < LV; j++) begin : g_lvl
    localparam int LD = 1 << (LV - 1 - j);
    logic [WIDTH-1:0] w_in;
    logic             w_en, w_f;
    shift_mode_t      w_m;
    logic [LD-1:0]    w_disc;
    if (j < H) begin : g_s1
      assign w_in = w_ch[j];
      assign w_en = in_shift[LV-1-j];
      assign w_m  = w_mode;
      assign w_f  = w_fill;
    end else begin : g_s2
      // first S2 level picks up the S1 register instead of the chain
      assign w_in = (j == H) ? r_s1_data : w_ch[j];
      assign w_en = r_s1_amt[LV-1-j] & ~r_s1_ovf;
      assign w_m  = r_s1_mode;
      assign w_f  = r_s1_fill;
    end
    mac_shift_level #(.WIDTH(WIDTH), .DIST(LD)) u_lvl (
      .i_data(w_in), .i_en(w_en), .i_mode(w_m), .i_fill(w_f),
      .o_data(w_ch[j+1]), .o_disc(w_disc)
    );
    assign w_dor[j] = |w_disc;
  end

  // over-range: the whole word goes out, so the result is pure fill
  assign w_s1_data   = w_ovf ? {WIDTH{w_fill}} : w_ch[H];
  assign w_s1_sticky = w_ovf ? (|in_data) : (|w_dor[H-1:0]);
  assign w_s2_data   = (r_s1_mode == MODE_LSL) ? f_rev(w_ch[LV]) : w_ch[LV];
  assign w_s2_sticky = r_s1_sticky | (|w_dor[LV-1:H]);

  assign w_s2_adv = !r_s2_vld || out_ready;
  assign w_s1_ld  = !r_s1_vld || w_s2_adv;
  assign in_ready = !rst && w_s1_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_data   <= '0;
      r_s1_amt    <= '0;
      r_s1_mode   <= MODE_LSR;
      r_s1_fill   <= 1'b0;
      r_s1_ovf    <= 1'b0;
      r_s1_sticky <= 1'b0;
    end else if (w_s1_ld) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_data   <= w_s1_data;
        r_s1_amt    <= in_shift[LV-H-1:0];
        r_s1_mode   <= w_mode;
        r_s1_fill   <= w_fill;
        r_s1_ovf    <= w_ovf;
        r_s1_sticky <= w_s1_sticky;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld     <= 1'b0;
      r_out_data   <= '0;
      r_out_sticky <= 1'b0;
      r_out_ovf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_data   <= w_s2_data;
        r_out_sticky <= w_s2_sticky;
        r_out_ovf    <= r_s1_ovf;
      end
    end
  end

  assign out_valid  = r_s2_vld;
  assign out_data   = r_out_data;
  assign out_sticky = r_out_sticky;
  assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_mac_align_shifter.sv
// tb_mac_align_shifter: directed + random checks of mac_align_shifter
// against an arithmetic reference model and a result scoreboard.
module tb_mac_align_shifter;
  localparam int W  = 32;
  localparam int SW = 6;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic          out_sticky, out_ovf;
  logic [W-1:0]  in_data = '0, out_data;
  logic [SW-1:0] in_shift = '0;
  logic [1:0]    in_mode = '0;

  int checks = 0, errors = 0, cons_cnt = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] cur_exp;
  logic         last_acc;

  always #5 clk = ~clk;

  mac_align_shifter #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .out_ovf(out_ovf)
  );

  // {data, sticky, ovf} computed from the mode definitions
  function automatic logic [W+1:0] model(input logic [W-1:0] d, input logic [SW-1:0] sh,
                                         input logic [1:0] m);
    longint unsigned dd, mask;
    longint          sx;
    int              s, k;
    logic [W-1:0]    r;
    logic            st, ov;
    dd = 64'(d); s = int'(sh); r = '0; st = 1'b0; ov = 1'b0;
    mask = (64'd1 << s) - 64'd1;
    case (m)
      2'd0: if (s >= W) begin r = '0; st = |d; ov = 1'b1; end
            else begin r = W'(dd >> s); st = (dd & mask) != 0; end
      2'd1: if (s >= W) begin r = {W{d[W-1]}}; st = |d; ov = 1'b1; end
            else begin sx = {{32{d[W-1]}}, d}; sx = sx >>> s; r = sx[W-1:0]; st = (dd & mask) != 0; end
      2'd2: if (s >= W) begin r = '0; st = |d; ov = 1'b1; end
            else begin r = W'(dd << s); st = (s != 0) && ((dd >> (W - s)) != 0); end
      default: begin k = s % W; r = W'((dd >> k) | (dd << (W - k))); end
    endcase
    return {r, st, ov};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: sample handshakes at negedge, settle #1 after posedge
  task automatic step();
    logic acc, cons;
    logic [W+1:0] got, e;
    @(negedge clk);
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    got  = {out_data, out_sticky, out_ovf};
    @(posedge clk); #1;
    last_acc = acc;
    if (cons) begin
      cons_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed %0h expected none", got);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(got[W+1:2]), 64'(e[W+1:2]));
        chk("out_sticky", 64'(got[1]), 64'(e[1]));
        chk("out_ovf", 64'(got[0]), 64'(e[0]));
      end
    end
    if (acc) exp_q.push_back(cur_exp);
  endtask

  task automatic drive(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [1:0] m,
                       input logic [W+1:0] ex);
    in_valid = 1'b1; in_data = d; in_shift = sh; in_mode = m; cur_exp = ex;
  endtask

  task automatic drive_rand();
    logic [W-1:0] d; logic [SW-1:0] sh; logic [1:0] m;
    d = $urandom; sh = SW'($urandom_range(0, 63)); m = 2'($urandom_range(0, 3));
    drive(d, sh, m, model(d, sh, m));
  endtask

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [1:0] m,
                      input logic [W+1:0] ex);
    int n;
    drive(d, sh, m, ex);
    n = 0;
    do begin step(); n++; end while (!last_acc && n < 20);
    chk("send_accept", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 30) begin step(); n++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [W-1:0]  VD [9] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0010, 32'h0000_00F1,
                                       32'hC000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
  localparam logic [SW-1:0] VS [9] = '{6'd1, 6'd4, 6'd40, 6'd36, 6'd1, 6'd63, 6'd0, 6'd31, 6'd32};
  localparam logic [1:0]    VM [9] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
  localparam logic [W-1:0]  VR [9] = '{32'h4000_0000, 32'hF800_0000, 32'hFFFF_FFFF, 32'h1000_000F,
                                       32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
  localparam logic          VT [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic          VO [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int c0, k, n;
    logic [W-1:0] hold;

    // reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sticky", 64'(out_sticky), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // directed vectors; first one also checks latency
    out_ready = 1'b1;
    send(VD[0], VS[0], VM[0], {VR[0], VT[0], VO[0]});
    chk("lat_after_accept", 64'(out_valid), 64'd0);
    step();
    chk("lat_next_edge", 64'(out_valid), 64'd1);
    for (int i = 1; i < 9; i++) send(VD[i], VS[i], VM[i], {VR[i], VT[i], VO[i]});
    drain();

    // full throughput: 64 back-to-back random beats
    c0 = cons_cnt;
    for (int i = 0; i < 64; i++) begin
      drive_rand();
      step();
      chk("tp_accept", 64'(last_acc), 64'd1);
      if (i >= 1) chk("tp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("tp_out_valid_last", 64'(out_valid), 64'd1);
    drain();
    chk("tp_count", 64'(cons_cnt - c0), 64'd64);

    // backpressure: 5 beats offered, out_ready low for 3 cycles
    c0 = cons_cnt; k = 0; hold = '0;
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (k < 5) drive_rand();
      step();
      if (last_acc) k++;
      if (t == 1) hold = out_data;
      if (t >= 1) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    chk("bp_accepted_two", 64'(k), 64'd2);
    chk("bp_hold_data", 64'(out_data), 64'(hold));
    out_ready = 1'b1; n = 0;
    while (k < 5 && n < 20) begin
      drive_rand();
      step();
      if (last_acc) k++;
      n++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(k), 64'd5);
    drain();
    chk("bp_count", 64'(cons_cnt - c0), 64'd5);

    // reset with two beats in flight
    drive_rand(); step();
    drive_rand(); step();
    in_valid = 1'b0;
    rst = 1'b1; #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    chk("midrst_after_valid", 64'(out_valid), 64'd0);
    c0 = cons_cnt;
    drive_rand();
    step();
    chk("midrst_accept", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    chk("midrst_lat_s1", 64'(out_valid), 64'd0);
    step();
    chk("midrst_lat_s2", 64'(out_valid), 64'd1);
    drain();
    chk("midrst_count", 64'(cons_cnt - c0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
